// File: rtl/dp_pkg.sv
// Shared encodings and helpers for the multi-cycle datapath.
// Holds the ALU, branch and write-back codes, the FSM state type and immediate sign extension.
package dp_pkg;

    localparam logic [4:0] ALU_PASS = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_MUL  = 5'd3;
    localparam logic [4:0] ALU_DIV  = 5'd4;
    localparam logic [4:0] ALU_MOD  = 5'd5;
    localparam logic [4:0] ALU_OR   = 5'd6;
    localparam logic [4:0] ALU_AND  = 5'd7;
    localparam logic [4:0] ALU_XOR  = 5'd8;
    localparam logic [4:0] ALU_NOT  = 5'd9;
    localparam logic [4:0] ALU_SHR1 = 5'd10;
    localparam logic [4:0] ALU_SHL1 = 5'd11;

    localparam logic [2:0] PC_NEXT   = 3'd0;
    localparam logic [2:0] PC_EQ     = 3'd1;
    localparam logic [2:0] PC_LT     = 3'd2;
    localparam logic [2:0] PC_GT     = 3'd3;
    localparam logic [2:0] PC_NE     = 3'd4;
    localparam logic [2:0] PC_LE     = 3'd5;
    localparam logic [2:0] PC_GE     = 3'd6;
    localparam logic [2:0] PC_ALWAYS = 3'd7;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_NUM2 = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;
    localparam logic [1:0] WB_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD1  = 2'd1,
        ST_RD2  = 2'd2,
        ST_EXEC = 2'd3
    } state_t;

    // Replicates bit from_w-1 into every higher bit of a 64-bit container.
    function automatic logic [63:0] sign_extend(input logic [63:0] value, input int unsigned from_w);
        logic [63:0] r;
        r = value;
        for (int i = 0; i < 64; i++) begin
            if (i >= from_w) r[i] = value[from_w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU for the multi-cycle datapath.
// Divide/modulo are unsigned; a zero divisor or an unknown opcode yields all-ones.
module dp_alu
    import dp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       alucode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             div0
);

    always_comb begin
        y    = '1;
        div0 = 1'b0;
        case (alucode)
            ALU_PASS: y = a;
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_MUL:  y = a * b;
            ALU_DIV: begin
                if (b == '0) div0 = 1'b1;
                else         y = a / b;
            end
            ALU_MOD: begin
                if (b == '0) div0 = 1'b1;
                else         y = a % b;
            end
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            ALU_XOR:  y = a ^ b;
            ALU_NOT:  y = ~a;
            ALU_SHR1: y = a >> 1;
            ALU_SHL1: y = a << 1;
            default:  y = '1;
        endcase
    end

endmodule

// File: rtl/dp_mc_datapath.sv
// Multi-cycle datapath: register file, ALU, PC/branch unit and a req/ack memory-operand path.
// One decoded instruction is accepted in IDLE, optional operand reads follow, and EXEC commits.
module dp_mc_datapath
    import dp_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 8,
    parameter int IMM_W  = 21,
    parameter int ADDR_W = 10
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  logic [4:0]                 alucode,
    input  logic [$clog2(NREGS)-1:0]   rd,
    input  logic [$clog2(NREGS)-1:0]   rs,
    input  logic [$clog2(NREGS)-1:0]   rt,
    input  logic [IMM_W-1:0]           imm,
    input  logic                       imm_sel,
    input  logic                       mem_src1,
    input  logic                       mem_src2,
    input  logic                       reg_we,
    input  logic [1:0]                 wb_sel,
    input  logic [2:0]                 pc_ctrl,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [WIDTH-1:0]           mem_rdata,
    input  logic                       mem_ack,
    output logic [WIDTH-1:0]           pc,
    output logic [WIDTH-1:0]           result,
    output logic                       busy,
    output logic                       err_div0
);

    localparam int RA_W = $clog2(NREGS);

    state_t             state_reg;
    logic [WIDTH-1:0]   regs [NREGS];
    logic [WIDTH-1:0]   pc_reg, result_reg, op1_reg, op2_reg;
    logic               err_div0_reg;

    logic [4:0]         alucode_reg;
    logic [RA_W-1:0]    rd_reg, rs_reg, rt_reg;
    logic [IMM_W-1:0]   imm_reg;
    logic               imm_sel_reg, mem_src1_reg, mem_src2_reg, reg_we_reg;
    logic [1:0]         wb_sel_reg;
    logic [2:0]         pc_ctrl_reg;

    logic [WIDTH-1:0]   rs_val, rt_val, imm_ext, num1, num2, alu_y, wb_value, pc_plus1;
    logic               alu_div0, taken, need_rd2;

    assign rs_val   = regs[rs_reg];
    assign rt_val   = regs[rt_reg];
    assign imm_ext  = WIDTH'(sign_extend(64'(imm_reg), IMM_W));
    assign num1     = mem_src1_reg ? op1_reg : rs_val;
    assign num2     = imm_sel_reg ? imm_ext : (mem_src2_reg ? op2_reg : rt_val);
    assign pc_plus1 = pc_reg + WIDTH'(1);
    assign need_rd2 = mem_src2_reg & ~imm_sel_reg;

    dp_alu #(.WIDTH(WIDTH)) u_alu (
        .alucode (alucode_reg),
        .a       (num1),
        .b       (num2),
        .y       (alu_y),
        .div0    (alu_div0)
    );

    always_comb begin
        taken = 1'b0;
        case (pc_ctrl_reg)
            PC_NEXT:   taken = 1'b0;
            PC_EQ:     taken = (num1 == num2);
            PC_LT:     taken = (num1 <  num2);
            PC_GT:     taken = (num1 >  num2);
            PC_NE:     taken = (num1 != num2);
            PC_LE:     taken = (num1 <= num2);
            PC_GE:     taken = (num1 >= num2);
            PC_ALWAYS: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

    always_comb begin
        wb_value = '1;
        case (wb_sel_reg)
            WB_ALU:  wb_value = alu_y;
            WB_NUM2: wb_value = num2;
            WB_LINK: wb_value = pc_plus1;
            WB_RSVD: wb_value = '1;
            default: wb_value = '1;
        endcase
    end

    // Operand address comes straight from the (frozen) register file, so it stays stable until ack.
    assign mem_req     = (state_reg == ST_RD1) || (state_reg == ST_RD2);
    assign mem_addr    = (state_reg == ST_RD2) ? rt_val[ADDR_W-1:0] : rs_val[ADDR_W-1:0];
    assign instr_ready = (state_reg == ST_IDLE);
    assign busy        = ~instr_ready;
    assign pc          = pc_reg;
    assign result      = result_reg;
    assign err_div0    = err_div0_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= '0;
            result_reg   <= '0;
            op1_reg      <= '0;
            op2_reg      <= '0;
            err_div0_reg <= 1'b0;
            alucode_reg  <= '0;
            rd_reg       <= '0;
            rs_reg       <= '0;
            rt_reg       <= '0;
            imm_reg      <= '0;
            imm_sel_reg  <= 1'b0;
            mem_src1_reg <= 1'b0;
            mem_src2_reg <= 1'b0;
            reg_we_reg   <= 1'b0;
            wb_sel_reg   <= '0;
            pc_ctrl_reg  <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (instr_valid) begin
                        alucode_reg  <= alucode;
                        rd_reg       <= rd;
                        rs_reg       <= rs;
                        rt_reg       <= rt;
                        imm_reg      <= imm;
                        imm_sel_reg  <= imm_sel;
                        mem_src1_reg <= mem_src1;
                        mem_src2_reg <= mem_src2;
                        reg_we_reg   <= reg_we;
                        wb_sel_reg   <= wb_sel;
                        pc_ctrl_reg  <= pc_ctrl;
                        if (mem_src1)                 state_reg <= ST_RD1;
                        else if (mem_src2 && !imm_sel) state_reg <= ST_RD2;
                        else                          state_reg <= ST_EXEC;
                    end
                end
                ST_RD1: begin
                    if (mem_ack) begin
                        op1_reg   <= mem_rdata;
                        state_reg <= need_rd2 ? ST_RD2 : ST_EXEC;
                    end
                end
                ST_RD2: begin
                    if (mem_ack) begin
                        op2_reg   <= mem_rdata;
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // rt_val is read before this edge's write, so rd==rt still branches on the old value.
                    if (reg_we_reg) regs[rd_reg] <= wb_value;
                    result_reg <= alu_y;
                    pc_reg     <= taken ? (pc_reg + rt_val) : pc_plus1;
                    if (alu_div0) err_div0_reg <= 1'b1;
                    state_reg  <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
